// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the shared-register write arbiter.
// Imported by the arbiter top and its round-robin picker.
package shared_reg_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational rotating-priority search: first set req bit
// at or above ptr, wrapping from N-1 back to 0.
module rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] win
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off;
    int             idx;

    // Rotate so ptr lands at bit 0; lowest set bit is then the winner.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        any = 1'b0;
        off = 0;
        for (int i = 0; i < N; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                off = i;
            end
        end
        idx = int'(ptr) + off;
        if (idx >= N) begin
            idx = idx - N;
        end
        win = IW'(idx);
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared W-bit register:
// select in IDLE, commit latched data during the one-cycle GRANT.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int IW = id_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]  gnt,
    output logic [W-1:0]  q,
    output logic          busy,
    output logic [IW-1:0] last_id
);

    state_t        state;
    state_t        state_n;
    logic [IW-1:0] ptr;
    logic [IW-1:0] sel;
    logic [IW-1:0] win;
    logic [W-1:0]  dlat;
    logic          any;
    logic          load;
    logic          commit;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .any (any),
        .win (win)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    load    = 1'b1;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                commit  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Data is captured at selection so late wdata edits cannot leak in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr     <= '0;
            sel     <= '0;
            dlat    <= '0;
            q       <= '0;
            gnt     <= '0;
            last_id <= '0;
        end else begin
            gnt <= '0;
            if (load) begin
                sel  <= win;
                dlat <= wdata[int'(win)*W +: W];
                gnt  <= N'(1) << win;
            end
            if (commit) begin
                q       <= dlat;
                last_id <= sel;
                ptr     <= (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
            end
        end
    end

    assign busy = (state == GRANT);

endmodule
